// File: rtl/nib_dmem_arbiter_if.sv
// nib_dmem_arbiter_if: load/store bus between a core (or the arbiter) and the data-RAM port.
// With NIB_ARB_LOCK_EN the requester side also carries a lock bit.
interface nib_dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              hold;
`ifdef NIB_ARB_LOCK_EN
  logic              lock;
  modport slave (input req, addr, we, wdata, lock, output rdata, hold);
`else
  modport slave (input req, addr, we, wdata, output rdata, hold);
`endif
  modport master (output req, addr, we, wdata, input rdata);
endinterface

// File: rtl/nib_dmem_arbiter.sv
// nib_dmem_arbiter: two-master data-RAM arbiter with burst-limited fairness and tagged read return.
// Define NIB_ARB_LOCK_EN to let the current owner keep the port past the burst limit.
module nib_dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  nib_dmem_arbiter_if.slave     m0,
  nib_dmem_arbiter_if.slave     m1,
  nib_dmem_arbiter_if.master    s,
  output logic [1:0]            grant_o
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam logic [3:0] LIM = 4'(MAX_BURST);
  state_t                r_state, w_state_n;
  logic [3:0]            r_cnt, w_cnt_n;
  logic                  w_g0, w_g1, w_lock0, w_lock1, w_keep0, w_keep1, w_rd;
  logic [RD_LATENCY-1:0] r_tv, r_tid;
  logic [DATA_W-1:0]     r_rd0, r_rd1;
`ifdef NIB_ARB_LOCK_EN
  assign w_lock0 = m0.lock;
  assign w_lock1 = m1.lock;
`else
  assign w_lock0 = 1'b0;
  assign w_lock1 = 1'b0;
`endif
  // Owner keeps the port unless the other side has waited out the burst limit
  assign w_keep0 = m0.req & (~m1.req | (r_cnt < LIM) | w_lock0);
  assign w_keep1 = m1.req & (~m0.req | (r_cnt < LIM) | w_lock1);
  always_comb begin
    w_g0      = 1'b0;
    w_g1      = 1'b0;
    w_state_n = r_state;
    w_cnt_n   = 4'd0;
    case (r_state)
      OWN0: begin
        w_g0      = w_keep0;
        w_g1      = ~w_keep0 & m1.req;
        w_state_n = w_g0 ? OWN0 : w_g1 ? OWN1 : IDLE;
        w_cnt_n   = (w_g0 & m1.req) ? ((r_cnt == LIM) ? r_cnt : r_cnt + 4'd1) : 4'd0;
      end
      OWN1: begin
        w_g1      = w_keep1;
        w_g0      = ~w_keep1 & m0.req;
        w_state_n = w_g1 ? OWN1 : w_g0 ? OWN0 : IDLE;
        w_cnt_n   = (w_g1 & m0.req) ? ((r_cnt == LIM) ? r_cnt : r_cnt + 4'd1) : 4'd0;
      end
      default: begin
        w_g0      = m0.req;
        w_g1      = ~m0.req & m1.req;
        w_state_n = w_g0 ? OWN0 : w_g1 ? OWN1 : IDLE;
      end
    endcase
  end
  assign grant_o  = {w_g1, w_g0};
  assign s.req    = w_g0 | w_g1;
  assign s.addr   = w_g0 ? m0.addr  : w_g1 ? m1.addr  : '0;
  assign s.we     = w_g0 ? m0.we    : w_g1 ? m1.we    : 1'b0;
  assign s.wdata  = w_g0 ? m0.wdata : w_g1 ? m1.wdata : '0;
  assign m0.hold  = m0.req & ~w_g0;
  assign m1.hold  = m1.req & ~w_g1;
  assign m0.rdata = r_rd0;
  assign m1.rdata = r_rd1;
  assign w_rd     = s.req & ~s.we;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end
  // Tag pipe tracks which master owns the read data arriving RD_LATENCY cycles later
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tv  <= '0;
      r_tid <= '0;
      r_rd0 <= '0;
      r_rd1 <= '0;
    end else begin
      r_tv[0]  <= w_rd;
      r_tid[0] <= w_g1;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_tv[i]  <= r_tv[i-1];
        r_tid[i] <= r_tid[i-1];
      end
      if (r_tv[RD_LATENCY-1] && !r_tid[RD_LATENCY-1]) r_rd0 <= s.rdata;
      if (r_tv[RD_LATENCY-1] && r_tid[RD_LATENCY-1])  r_rd1 <= s.rdata;
    end
  end
endmodule
